// File: rtl/timing_param_loader.sv
// Stages timing parameters, validates the full set one check per cycle, then loads it on a frame boundary.
// Define TIMING_PARAM_READBACK_EN to add the registered rd_addr/rd_data readback port.
module timing_param_loader #(
    parameter int SYNC_TIMEOUT = 100000000,
    parameter int TIMEOUT_W    = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    input  logic        frame_sync,
    output logic [15:0] cmos_freq,
    output logic [15:0] cmos_width,
    output logic [31:0] laser_freq,
    output logic [31:0] laser_width,
    output logic [31:0] frame_gate_width_a,
    output logic [31:0] frame_gate_delay_a,
    output logic [31:0] frame_gate_width_b,
    output logic [31:0] frame_gate_delay_b,
    output logic [7:0]  tim_cycles_m,
    output logic [7:0]  delay_step_delta_t,
    output logic [15:0] bg_frame_deci_n,
    output logic        load_param,
    output logic        busy,
    output logic [4:0]  param_err,
    output logic        sync_timeout,
    output logic        wr_drop
`ifdef TIMING_PARAM_READBACK_EN
    ,
    input  logic [3:0]  rd_addr,
    output logic [31:0] rd_data
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        (SYNC_TIMEOUT > 0) ? TIMEOUT_W'(SYNC_TIMEOUT - 1) : '0;

    typedef struct packed {
        logic [15:0] cmos_freq;
        logic [15:0] cmos_width;
        logic [31:0] laser_freq;
        logic [31:0] laser_width;
        logic [31:0] gw_a;
        logic [31:0] gd_a;
        logic [31:0] gw_b;
        logic [31:0] gd_b;
        logic [7:0]  tim_m;
        logic [7:0]  dstep;
        logic [15:0] deci;
    } param_t;

    param_t                 stg_q, stg_d;
    param_t                 act_q, act_d;
    logic [1:0]             state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [4:0]             param_err_q, param_err_d;
    logic                   sync_timeout_q, sync_timeout_d;
    logic                   load_param_q, load_param_d;
    logic                   wr_drop_q, wr_drop_d;
    logic [4:0]             fail_vec;
    logic [32:0]            sum_a, sum_b;

    // Gate sums are widened to 33 bits so delay+width can never wrap past laser_freq.
    always_comb begin
        sum_a       = {1'b0, stg_q.gd_a} + {1'b0, stg_q.gw_a};
        sum_b       = {1'b0, stg_q.gd_b} + {1'b0, stg_q.gw_b};
        fail_vec[0] = (stg_q.cmos_freq == '0) || (stg_q.cmos_width >= stg_q.cmos_freq);
        fail_vec[1] = (stg_q.laser_freq == '0) || (stg_q.laser_width >= stg_q.laser_freq);
        fail_vec[2] = sum_a > {1'b0, stg_q.laser_freq};
        fail_vec[3] = sum_b > {1'b0, stg_q.laser_freq};
        fail_vec[4] = (stg_q.tim_m == '0);
    end

    always_comb begin
        stg_d          = stg_q;
        act_d          = act_q;
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        param_err_d    = param_err_q;
        sync_timeout_d = sync_timeout_q;
        load_param_d   = 1'b0;
        wr_drop_d      = 1'b0;

        if (busy_q) begin
            wr_drop_d = wr_en | commit;
        end else if (wr_en) begin
            case (wr_addr)
                4'd0: stg_d.cmos_freq   = wr_data[15:0];
                4'd1: stg_d.cmos_width  = wr_data[15:0];
                4'd2: stg_d.laser_freq  = wr_data;
                4'd3: stg_d.laser_width = wr_data;
                4'd4: stg_d.gw_a        = wr_data;
                4'd5: stg_d.gd_a        = wr_data;
                4'd6: stg_d.gw_b        = wr_data;
                4'd7: stg_d.gd_b        = wr_data;
                4'd8: begin
                    stg_d.dstep = wr_data[15:8];
                    stg_d.tim_m = wr_data[7:0];
                end
                4'd9: stg_d.deci        = wr_data[15:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (commit && !busy_q) begin
                    state_d        = S_CHECK;
                    idx_d          = 3'd0;
                    param_err_d    = '0;
                    sync_timeout_d = 1'b0;
                    busy_d         = 1'b1;
                end
            end
            S_CHECK: begin
                if (fail_vec[idx_q]) param_err_d[idx_q] = 1'b1;
                if (idx_q == 3'd4) begin
                    if (param_err_d != '0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else if (SYNC_TIMEOUT == 0) begin
                        state_d      = S_LOAD;
                        act_d        = stg_q;
                        load_param_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                // A sync arriving on the timeout cycle wins, so the timeout flag stays clear.
                if (frame_sync || (cnt_q == TO_LAST)) begin
                    if (!frame_sync) sync_timeout_d = 1'b1;
                    state_d      = S_LOAD;
                    act_d        = stg_q;
                    load_param_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q          <= '0;
            act_q          <= '0;
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            param_err_q    <= '0;
            sync_timeout_q <= 1'b0;
            load_param_q   <= 1'b0;
            wr_drop_q      <= 1'b0;
        end else begin
            stg_q          <= stg_d;
            act_q          <= act_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            param_err_q    <= param_err_d;
            sync_timeout_q <= sync_timeout_d;
            load_param_q   <= load_param_d;
            wr_drop_q      <= wr_drop_d;
        end
    end

    assign cmos_freq          = act_q.cmos_freq;
    assign cmos_width         = act_q.cmos_width;
    assign laser_freq         = act_q.laser_freq;
    assign laser_width        = act_q.laser_width;
    assign frame_gate_width_a = act_q.gw_a;
    assign frame_gate_delay_a = act_q.gd_a;
    assign frame_gate_width_b = act_q.gw_b;
    assign frame_gate_delay_b = act_q.gd_b;
    assign tim_cycles_m       = act_q.tim_m;
    assign delay_step_delta_t = act_q.dstep;
    assign bg_frame_deci_n    = act_q.deci;
    assign load_param         = load_param_q;
    assign busy               = busy_q;
    assign param_err          = param_err_q;
    assign sync_timeout       = sync_timeout_q;
    assign wr_drop            = wr_drop_q;

`ifdef TIMING_PARAM_READBACK_EN
    logic [31:0] rd_data_q, rd_data_d;

    // Address 15 is the status word; other unmapped addresses read zero.
    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            4'd0:  rd_data_d = {16'b0, stg_q.cmos_freq};
            4'd1:  rd_data_d = {16'b0, stg_q.cmos_width};
            4'd2:  rd_data_d = stg_q.laser_freq;
            4'd3:  rd_data_d = stg_q.laser_width;
            4'd4:  rd_data_d = stg_q.gw_a;
            4'd5:  rd_data_d = stg_q.gd_a;
            4'd6:  rd_data_d = stg_q.gw_b;
            4'd7:  rd_data_d = stg_q.gd_b;
            4'd8:  rd_data_d = {16'b0, stg_q.dstep, stg_q.tim_m};
            4'd9:  rd_data_d = {16'b0, stg_q.deci};
            4'd15: rd_data_d = {25'b0, sync_timeout_q, busy_q, param_err_q};
            default: rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_timing_param_loader.sv
// Directed bench for timing_param_loader: expected loads go to a scoreboard queue,
// a monitor compares them whenever load_param is seen.
module tb_timing_param_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] cmos_freq, cmos_width, bg_frame_deci_n;
    logic [31:0] laser_freq, laser_width;
    logic [31:0] frame_gate_width_a, frame_gate_delay_a, frame_gate_width_b, frame_gate_delay_b;
    logic [7:0]  tim_cycles_m, delay_step_delta_t;
    logic        load_param, busy, sync_timeout, wr_drop;
    logic [4:0]  param_err;
    logic [255:0] out_vec;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    // Hand-computed active image of the valid set: 1000,100,200,20, A w/d 30/50, B w/d 40/80, m=1, dt=2, deci=10.
    localparam logic [255:0] VEC_VALID = {16'd1000, 16'd100, 32'd200, 32'd20,
                                          32'd30, 32'd50, 32'd40, 32'd80,
                                          8'd1, 8'd2, 16'd10};

    typedef struct {
        logic [255:0] vec;
        int           cyc;
        logic         sto;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign out_vec = {cmos_freq, cmos_width, laser_freq, laser_width,
                      frame_gate_width_a, frame_gate_delay_a, frame_gate_width_b, frame_gate_delay_b,
                      tim_cycles_m, delay_step_delta_t, bg_frame_deci_n};

    timing_param_loader #(.SYNC_TIMEOUT(16), .TIMEOUT_W(27)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .frame_sync(frame_sync),
        .cmos_freq(cmos_freq), .cmos_width(cmos_width),
        .laser_freq(laser_freq), .laser_width(laser_width),
        .frame_gate_width_a(frame_gate_width_a), .frame_gate_delay_a(frame_gate_delay_a),
        .frame_gate_width_b(frame_gate_width_b), .frame_gate_delay_b(frame_gate_delay_b),
        .tim_cycles_m(tim_cycles_m), .delay_step_delta_t(delay_step_delta_t),
        .bg_frame_deci_n(bg_frame_deci_n), .load_param(load_param), .busy(busy),
        .param_err(param_err), .sync_timeout(sync_timeout), .wr_drop(wr_drop)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_commit(output int t);
        t = cyc;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic pulse_sync(input int s);
        wait_cyc(s);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic push(input int c, input logic sto);
        exp_t e;
        e.vec = VEC_VALID;
        e.cyc = c;
        e.sto = sto;
        exp_q.push_back(e);
    endtask

    initial begin
        int t, t2, t3, t4, t5;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (load_param === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_load_param", 256'(load_param), 256'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("load_cycle", 256'(cyc), 256'(e.cyc));
                            chk("load_values", out_vec, e.vec);
                            chk("load_sync_timeout", 256'(sync_timeout), 256'(e.sto));
                            chk("load_param_err", 256'(param_err), 256'd0);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec, 256'd0);
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_param_err", 256'(param_err), 256'd0);
        chk("reset_sync_timeout", 256'(sync_timeout), 256'd0);
        chk("reset_load_param", 256'(load_param), 256'd0);
        chk("reset_wr_drop", 256'(wr_drop), 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Valid set, upper data bits set on 16-bit fields, plus an ignored address.
        wr(4'd0, 32'hABCD_03E8); wr(4'd1, 32'd100); wr(4'd2, 32'd200); wr(4'd3, 32'd20);
        wr(4'd4, 32'd30); wr(4'd5, 32'd50); wr(4'd6, 32'd40); wr(4'd7, 32'd80);
        wr(4'd8, 32'hFFFF_0201); wr(4'd9, 32'd10); wr(4'd12, 32'hDEAD_BEEF);
        chk("idle_write_no_drop", 256'(wr_drop), 256'd0);
        do_commit(t);
        push(t + 21, 1'b0);
        chk("busy_after_commit", 256'(busy), 256'd1);
        chk("outputs_before_load", out_vec, 256'd0);
        wait_cyc(t + 5);
        chk("busy_in_check", 256'(busy), 256'd1);
        pulse_sync(t + 20);
        chk("busy_in_load", 256'(busy), 256'd1);
        wait_cyc(t + 22);
        chk("busy_low_after_load", 256'(busy), 256'd0);

        // laser_width == laser_freq and gate B 180+40 > 200: bits 1 and 3.
        wr(4'd3, 32'd200); wr(4'd7, 32'd180);
        do_commit(t);
        wait_cyc(t + 5);
        chk("busy_err_check", 256'(busy), 256'd1);
        wait_cyc(t + 6);
        chk("param_err_b1_b3", 256'(param_err), 256'h0A);
        wait_cyc(t + 7);
        chk("busy_low_after_err", 256'(busy), 256'd0);
        pulse_sync(t + 7);
        wait_cyc(t + 10);
        chk("active_unchanged_after_err", out_vec, VEC_VALID);
        chk("param_err_sticky", 256'(param_err), 256'h0A);

        // Gate A delay 0xFFFFFFFF + width 2 exceeds laser_freq 0xFFFFFFFF without wrapping.
        wr(4'd2, 32'hFFFF_FFFF); wr(4'd5, 32'hFFFF_FFFF); wr(4'd4, 32'd2);
        do_commit(t);
        wait_cyc(t + 6);
        chk("param_err_33bit_sum", 256'(param_err), 256'h04);
        wait_cyc(t + 7);
        chk("busy_low_33bit", 256'(busy), 256'd0);

        // Restore the valid set and let the sync wait time out.
        wr(4'd2, 32'd200); wr(4'd3, 32'd20); wr(4'd4, 32'd30); wr(4'd5, 32'd50); wr(4'd7, 32'd80);
        do_commit(t);
        push(t + 22, 1'b1);
        wait_cyc(t + 21);
        chk("no_timeout_yet", 256'(sync_timeout), 256'd0);
        wait_cyc(t + 22);
        chk("timeout_flag_set", 256'(sync_timeout), 256'd1);
        wait_cyc(t + 23);
        chk("busy_low_after_timeout", 256'(busy), 256'd0);
        chk("timeout_flag_sticky", 256'(sync_timeout), 256'd1);

        do_commit(t2);
        push(t2 + 11, 1'b0);
        chk("timeout_cleared_by_commit", 256'(sync_timeout), 256'd0);
        pulse_sync(t2 + 10);
        wait_cyc(t2 + 12);
        chk("busy_fell", 256'(busy), 256'd0);

        // Commit in the cycle busy falls, then a write and a commit while waiting are dropped.
        do_commit(t3);
        push(t3 + 15, 1'b0);
        chk("commit_on_busy_fall_accepted", 256'(busy), 256'd1);
        wait_cyc(t3 + 8);
        wr(4'd2, 32'h0001_2345);
        chk("wr_drop_on_write", 256'(wr_drop), 256'd1);
        wait_cyc(t3 + 10);
        chk("wr_drop_single_cycle", 256'(wr_drop), 256'd0);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        chk("wr_drop_on_commit", 256'(wr_drop), 256'd1);
        pulse_sync(t3 + 14);
        wait_cyc(t3 + 16);
        chk("busy_low_after_drops", 256'(busy), 256'd0);

        // Reset while waiting for sync: everything clears and a later sync loads nothing.
        wait_cyc(t3 + 17);
        do_commit(t4);
        wait_cyc(t4 + 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_outputs", out_vec, 256'd0);
        chk("midreset_busy", 256'(busy), 256'd0);
        chk("midreset_load_param", 256'(load_param), 256'd0);
        chk("midreset_flags", 256'({sync_timeout, wr_drop, param_err}), 256'd0);
        pulse_sync(t4 + 12);
        wait_cyc(t4 + 30);
        chk("idle_after_midreset", 256'(busy), 256'd0);

        // Cleared staging: cmos_freq, laser_freq and tim_cycles_m fail; zero gates pass.
        do_commit(t5);
        wait_cyc(t5 + 6);
        chk("param_err_after_reset", 256'(param_err), 256'h13);
        wait_cyc(t5 + 7);
        chk("busy_low_final", 256'(busy), 256'd0);
        chk("active_still_zero", out_vec, 256'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
